// File: rtl/barcode_rx_param.sv
// barcode_rx_param: self-clocking barcode / serial ID receiver.
//   The low time T of the start bit sets the bit timing. Each data bit starts
//   with a falling edge, and the line is sampled T clocks after that fall.
//   Bits are assembled MSB-first and the frame is checked before it is accepted.
// Optional feature: define BC_PARITY_EN to expect one odd-parity bit after the data.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   BC           raw sensor line (asynchronous, idles high)
//   clr_ID_vld   synchronous clear of ID_vld
//   ID_vld       sticky flag: ID holds a valid frame
//   ID           last accepted frame (MSB = first data bit)
//   err          one-cycle pulse when a frame is rejected
//   busy         high while the receiver is not idle
module barcode_rx_param #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FILT_DEPTH = 3,
  parameter int unsigned TMR_W      = 22,
  parameter int unsigned CHK_BITS   = 2,
  parameter int unsigned MIN_START  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 BC,
  input  logic                 clr_ID_vld,
  output logic                 ID_vld,
  output logic [DATA_BITS-1:0] ID,
  output logic                 err,
  output logic                 busy
);

`ifdef BC_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned NB    = DATA_BITS + PAR_W;
  localparam int unsigned CNT_W = $clog2(NB + 1);

  // Mask that selects the top CHK_BITS data bits (all zero when CHK_BITS = 0).
  localparam logic [DATA_BITS-1:0] ALL_ONES = '1;
  localparam logic [DATA_BITS-1:0] CHK_MASK = ~(ALL_ONES >> CHK_BITS);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BITS, S_CHECK} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             sync_q;
  logic [FILT_DEPTH-2:0]  filt_q;
  logic [FILT_DEPTH-1:0]  taps_c;
  logic                   bcf_q, bcf_d;
  logic                   fall_c;
  logic [TMR_W-1:0]       t_q, t_d;
  logic [TMR_W-1:0]       baud_q, baud_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [NB-1:0]          shreg_q, shreg_d;
  logic                   armed_q, armed_d;
  logic [DATA_BITS-1:0]   id_q, id_d;
  logic                   vld_q, vld_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic [DATA_BITS-1:0]   data_c;
  logic                   frame_ok_c;
  logic [TMR_W+1:0]       baud_ext_c;
  logic [TMR_W+1:0]       tmo_lim_c;

  // Filter window: synchroniser output plus FILT_DEPTH-1 older samples.
  assign taps_c = {filt_q, sync_q[1]};

  // Filtered line changes only when the whole window agrees.
  always_comb begin
    bcf_d = bcf_q;
    if (&taps_c) begin
      bcf_d = 1'b1;
    end else if (~|taps_c) begin
      bcf_d = 1'b0;
    end
  end

  // Fall is flagged the cycle before bcf_q drops, so START counts from its first low cycle.
  assign fall_c = bcf_q & ~bcf_d;

  assign data_c     = shreg_q[NB-1 -: DATA_BITS];
  assign baud_ext_c = {2'b00, baud_q};
  assign tmo_lim_c  = {t_q, 2'b00};

`ifdef BC_PARITY_EN
  logic par_ok_c;
  // Odd parity across data and parity bit.
  assign par_ok_c   = ^shreg_q;
  assign frame_ok_c = ((data_c & CHK_MASK) == '0) && par_ok_c;
`else
  assign frame_ok_c = ((data_c & CHK_MASK) == '0);
`endif

  // Input synchroniser and filter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      filt_q <= '1;
      bcf_q  <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], BC};
      filt_q <= taps_c[FILT_DEPTH-2:0];
      bcf_q  <= bcf_d;
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      t_q       <= '0;
      baud_q    <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      armed_q   <= 1'b0;
      id_q      <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      armed_q   <= armed_d;
      id_q      <= id_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    baud_d    = baud_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    armed_d   = armed_q;
    id_d      = id_q;
    err_d     = 1'b0;
    vld_d     = clr_ID_vld ? 1'b0 : vld_q;

    case (state_q)
      S_IDLE: begin
        if (fall_c) begin
          state_d   = S_START;
          t_d       = '0;
          bit_cnt_d = '0;
          shreg_d   = '0;
        end
      end

      S_START: begin
        if (!bcf_q) begin
          if (t_q == '1) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            t_d = t_q + TMR_W'(1);
          end
        end else if (t_q >= TMR_W'(MIN_START)) begin
          state_d = S_BITS;
          baud_d  = '0;
          armed_d = 1'b0;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_BITS: begin
        if (fall_c) begin
          // Each fall restarts bit timing and arms exactly one sample.
          baud_d  = '0;
          armed_d = 1'b1;
        end else begin
          if (baud_q != '1) begin
            baud_d = baud_q + TMR_W'(1);
          end
          if (armed_q && (baud_q == t_q - TMR_W'(1))) begin
            shreg_d   = {shreg_q[NB-2:0], bcf_q};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            armed_d   = 1'b0;
            if (bit_cnt_q == CNT_W'(NB - 1)) begin
              state_d = S_CHECK;
            end
          end else if (baud_ext_c >= tmo_lim_c) begin
            // No fall for four bit times: line is stuck.
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      S_CHECK: begin
        if (frame_ok_c) begin
          id_d  = data_c;
          vld_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign ID_vld = vld_q;
  assign ID     = id_q;
  assign err    = err_q;
  assign busy   = busy_q;

endmodule
